// File: rtl/regs_xfer_pkg.sv
// ---------------------------------------------------------------------------
// regs_xfer_pkg
// Shared definitions for the index/stack register transfer controller:
//   - op_e    : command opcodes carried on cmd_op
//   - state_e : sequencer states
//   - sp_op_e : stack-pointer update selector
//   - idx_width() : width of an index field that can address NREG regs + S
// ---------------------------------------------------------------------------
package regs_xfer_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_MOV  = 2'd1,
        OP_PUSH = 2'd2,
        OP_PULL = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_XFER     = 3'd1,
        ST_PUSH_WR  = 3'd2,
        ST_PUSH_DEC = 3'd3,
        ST_PULL_INC = 3'd4,
        ST_PULL_RD  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        SP_HOLD = 2'd0,
        SP_INC  = 2'd1,
        SP_DEC  = 2'd2,
        SP_LOAD = 2'd3
    } sp_op_e;

    // Index fields must reach value NREG (which selects S); never narrower than 1 bit.
    function automatic int idx_width(input int nreg);
        int w;
        w = $clog2(nreg + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/regs_stack_ptr.sv
// ---------------------------------------------------------------------------
// regs_stack_ptr
// DW-wide stack pointer S with hold / increment / decrement / load, resetting
// to SP_INIT. Arithmetic wraps modulo 2^DW.
// Optional feature (macro REGS_STACK_GUARD_EN): sticky o_fault flag that sets
// when a decrement wraps 0 -> all-ones or an increment wraps all-ones -> 0;
// cleared by reset or i_fault_clr. The wrap still happens.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_op                update selector (sp_op_e)
//   i_load_val          value for SP_LOAD
//   i_fault_clr/o_fault guard clear / sticky flag (macro only)
//   o_sp                current S
// ---------------------------------------------------------------------------
module regs_stack_ptr
    import regs_xfer_pkg::*;
#(
    parameter int                DW      = 8,
    parameter logic [DW-1:0]     SP_INIT = '1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  sp_op_e        i_op,
    input  logic [DW-1:0] i_load_val,
`ifdef REGS_STACK_GUARD_EN
    input  logic          i_fault_clr,
    output logic          o_fault,
`endif
    output logic [DW-1:0] o_sp
);

    logic [DW-1:0] r_sp;

    // S register update
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sp <= SP_INIT;
        end else begin
            case (i_op)
                SP_INC:  r_sp <= r_sp + DW'(1'b1);
                SP_DEC:  r_sp <= r_sp - DW'(1'b1);
                SP_LOAD: r_sp <= i_load_val;
                default: r_sp <= r_sp;
            endcase
        end
    end

    assign o_sp = r_sp;

`ifdef REGS_STACK_GUARD_EN
    logic r_fault;
    logic w_wrap;

    // Detect an update that is about to wrap around the address space
    always_comb begin
        w_wrap = 1'b0;
        if ((i_op == SP_DEC) && (r_sp == '0)) begin
            w_wrap = 1'b1;
        end else if ((i_op == SP_INC) && (&r_sp)) begin
            w_wrap = 1'b1;
        end else begin
            w_wrap = 1'b0;
        end
    end

    // Sticky guard flag; a wrap on the same edge as a clear wins
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fault <= 1'b0;
        end else if (w_wrap) begin
            r_fault <= 1'b1;
        end else if (i_fault_clr) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= r_fault;
        end
    end

    assign o_fault = r_fault;
`endif

endmodule

// File: rtl/regs_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// regs_xfer_ctrl
// NREG index registers plus stack pointer S. Sequences MOV transfers on the
// special bus (SB) and stack PUSH/PULL with S driven onto ADL. All outputs are
// registered; n_ready = 1 freezes any operation in progress.
// Optional feature: define REGS_STACK_GUARD_EN to add stk_fault.
// Ports:
//   PHI0, RES            clock, asynchronous active-high reset
//   n_ready              1 = stall
//   cmd_valid/op/src/dst command interface (index NREG = S)
//   sb_in                SB data captured at the end of a PULL
//   sb_out/sb_drive      SB output and its valid
//   adl_out/adl_drive    stack address low and its valid
//   busy                 operation in progress
//   err                  1-cycle pulse on a rejected illegal index
//   reg_q                {S, reg[NREG-1], ..., reg[0]}
//   stk_fault            sticky stack wrap flag (macro only)
// ---------------------------------------------------------------------------
module regs_xfer_ctrl
    import regs_xfer_pkg::*;
#(
    parameter int          DW      = 8,
    parameter int          NREG    = 2,
    parameter logic [31:0] SP_INIT = 32'h0000_00FF
) (
    input  logic                         PHI0,
    input  logic                         RES,
    input  logic                         n_ready,
    input  logic                         cmd_valid,
    input  logic [1:0]                   cmd_op,
    input  logic [idx_width(NREG)-1:0]   cmd_src,
    input  logic [idx_width(NREG)-1:0]   cmd_dst,
    input  logic [DW-1:0]                sb_in,
    output logic [DW-1:0]                sb_out,
    output logic                         sb_drive,
    output logic [DW-1:0]                adl_out,
    output logic                         adl_drive,
    output logic                         busy,
    output logic                         err,
`ifdef REGS_STACK_GUARD_EN
    output logic                         stk_fault,
`endif
    output logic [(NREG+1)*DW-1:0]       reg_q
);

    localparam int IW = idx_width(NREG);

    state_e        r_state, w_state_nxt;
    logic [DW-1:0] r_regs [NREG];
    logic [IW-1:0] r_src, r_dst;
    logic [DW-1:0] r_sb_out, w_sb_out_nxt;
    logic          r_sb_drive, w_sb_drive_nxt;
    logic [DW-1:0] r_adl_out, w_adl_out_nxt;
    logic          r_adl_drive, w_adl_drive_nxt;
    logic          r_busy;
    logic          r_err, w_err_nxt;

    logic [DW-1:0] w_sp, w_sp_load;
    sp_op_e        w_sp_op;
    logic [DW-1:0] w_rd [NREG+1];
    logic [DW-1:0] w_cmd_src_val, w_lat_src_val;
    logic          w_accept, w_illegal;
    logic          w_reg_we;
    logic [IW-1:0] w_reg_waddr;
    logic [DW-1:0] w_reg_wdata;
    logic          w_fault_clr;

    regs_stack_ptr #(
        .DW      (DW),
        .SP_INIT (SP_INIT[DW-1:0])
    ) u_sp (
        .i_clk       (PHI0),
        .i_rst       (RES),
        .i_op        (w_sp_op),
        .i_load_val  (w_sp_load),
`ifdef REGS_STACK_GUARD_EN
        .i_fault_clr (w_fault_clr),
        .o_fault     (stk_fault),
`endif
        .o_sp        (w_sp)
    );

    // Read view of the whole register set; slot NREG is S
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_rd[i] = r_regs[i];
        end
        w_rd[NREG] = w_sp;
    end

    // Source operand for a command being presented and for the latched command
    always_comb begin
        w_cmd_src_val = '0;
        w_lat_src_val = '0;
        if (cmd_src <= IW'(NREG)) begin
            w_cmd_src_val = w_rd[cmd_src];
        end else begin
            w_cmd_src_val = '0;
        end
        if (r_src <= IW'(NREG)) begin
            w_lat_src_val = w_rd[r_src];
        end else begin
            w_lat_src_val = '0;
        end
    end

    // Only the index fields the opcode actually uses are range-checked
    always_comb begin
        w_illegal = 1'b0;
        case (op_e'(cmd_op))
            OP_MOV:  w_illegal = (cmd_src > IW'(NREG)) || (cmd_dst > IW'(NREG));
            OP_PUSH: w_illegal = (cmd_src > IW'(NREG));
            OP_PULL: w_illegal = (cmd_dst > IW'(NREG));
            default: w_illegal = 1'b0;
        endcase
    end

    // Next state, next registered outputs, register/S write controls
    always_comb begin
        w_state_nxt     = r_state;
        w_sb_out_nxt    = r_sb_out;
        w_sb_drive_nxt  = r_sb_drive;
        w_adl_out_nxt   = r_adl_out;
        w_adl_drive_nxt = r_adl_drive;
        w_err_nxt       = 1'b0;
        w_accept        = 1'b0;
        w_sp_op         = SP_HOLD;
        w_sp_load       = '0;
        w_reg_we        = 1'b0;
        w_reg_waddr     = r_dst;
        w_reg_wdata     = '0;
        w_fault_clr     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && !n_ready && (op_e'(cmd_op) != OP_NOP)) begin
                    if (w_illegal) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        case (op_e'(cmd_op))
                            OP_MOV: begin
                                w_state_nxt    = ST_XFER;
                                w_sb_drive_nxt = 1'b1;
                                w_sb_out_nxt   = w_cmd_src_val;
                            end
                            OP_PUSH: begin
                                w_state_nxt     = ST_PUSH_WR;
                                w_sb_drive_nxt  = 1'b1;
                                w_sb_out_nxt    = w_cmd_src_val;
                                w_adl_drive_nxt = 1'b1;
                                w_adl_out_nxt   = w_sp;
                            end
                            OP_PULL: begin
                                w_state_nxt = ST_PULL_INC;
                            end
                            default: begin
                                w_state_nxt = ST_IDLE;
                            end
                        endcase
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (!n_ready) begin
                    w_state_nxt    = ST_IDLE;
                    w_sb_drive_nxt = 1'b0;
                    w_sb_out_nxt   = '0;
                    if (r_dst == IW'(NREG)) begin
                        w_sp_op     = SP_LOAD;
                        w_sp_load   = w_lat_src_val;
                        w_fault_clr = 1'b1;
                    end else begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = w_lat_src_val;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_PUSH_WR: begin
                if (!n_ready) begin
                    w_state_nxt     = ST_PUSH_DEC;
                    w_sb_drive_nxt  = 1'b0;
                    w_sb_out_nxt    = '0;
                    w_adl_drive_nxt = 1'b0;
                    w_adl_out_nxt   = '0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_PUSH_DEC: begin
                if (!n_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_sp_op     = SP_DEC;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_PULL_INC: begin
                if (!n_ready) begin
                    // ADL must show the incremented S in PULL_RD, so precompute it
                    w_state_nxt     = ST_PULL_RD;
                    w_sp_op         = SP_INC;
                    w_adl_drive_nxt = 1'b1;
                    w_adl_out_nxt   = w_sp + DW'(1'b1);
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_PULL_RD: begin
                if (!n_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_adl_drive_nxt = 1'b0;
                    w_adl_out_nxt   = '0;
                    if (r_dst == IW'(NREG)) begin
                        w_sp_op   = SP_LOAD;
                        w_sp_load = sb_in;
                    end else begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = sb_in;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_sb_drive_nxt  = 1'b0;
                w_sb_out_nxt    = '0;
                w_adl_drive_nxt = 1'b0;
                w_adl_out_nxt   = '0;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge PHI0 or posedge RES) begin
        if (RES) begin
            r_state     <= ST_IDLE;
            r_sb_out    <= '0;
            r_sb_drive  <= 1'b0;
            r_adl_out   <= '0;
            r_adl_drive <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sb_out    <= w_sb_out_nxt;
            r_sb_drive  <= w_sb_drive_nxt;
            r_adl_out   <= w_adl_out_nxt;
            r_adl_drive <= w_adl_drive_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_err       <= w_err_nxt;
        end
    end

    // Latch operand indices on acceptance
    always_ff @(posedge PHI0 or posedge RES) begin
        if (RES) begin
            r_src <= '0;
            r_dst <= '0;
        end else if (w_accept) begin
            r_src <= cmd_src;
            r_dst <= cmd_dst;
        end
    end

    // Index register file
    always_ff @(posedge PHI0 or posedge RES) begin
        if (RES) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_reg_we && (w_reg_waddr == IW'(i))) begin
                    r_regs[i] <= w_reg_wdata;
                end
            end
        end
    end

    // Flat readback, S in the top slice
    always_comb begin
        reg_q = '0;
        for (int i = 0; i <= NREG; i++) begin
            reg_q[i*DW +: DW] = w_rd[i];
        end
    end

    assign sb_out    = r_sb_out;
    assign sb_drive  = r_sb_drive;
    assign adl_out   = r_adl_out;
    assign adl_drive = r_adl_drive;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule
